// File: rtl/pio_led_blink.sv
// pio_led_blink: Avalon-MM LED port with set/clear writes and optional masked blinking.
// Define PIO_LED_BLINK_EN to add BLINK_MASK, PERIOD, STATUS and the blink prescaler.
module pio_led_blink #(
  parameter int WIDTH = 8,
  parameter int PRESCALE_W = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_data;
  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) r_data <= RESET_VALUE;
    else if (w_wr && address == 3'd0) r_data <= w_wd;
    else if (w_wr && address == 3'd4) r_data <= r_data | w_wd;
    else if (w_wr && address == 3'd5) r_data <= r_data & ~w_wd;
  end
`ifdef PIO_LED_BLINK_EN
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  logic [WIDTH-1:0]      r_mask;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;
  always_ff @(posedge clk) begin
    if (reset) r_mask <= '0;
    else if (w_wr && address == 3'd1) r_mask <= w_wd;
  end
  // A PERIOD write restarts the blink cycle and wins over a coincident wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (w_wr && address == 3'd2) begin
      r_period <= writedata[PRESCALE_W-1:0];
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_cnt == r_period - ONE) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + ONE;
    end
  end
  assign w_out = r_data & (~r_mask | {WIDTH{r_phase}});
  always_comb
    readdata = address == 3'd0 ? 32'(r_data) :
               address == 3'd1 ? 32'(r_mask) :
               address == 3'd2 ? 32'(r_period) :
               address == 3'd3 ? {31'd0, r_phase} : 32'd0;
`else
  assign w_out = r_data;
  always_comb readdata = address == 3'd0 ? 32'(r_data) : 32'd0;
`endif
  always_ff @(posedge clk) begin
    if (reset) out_port <= '0;
    else out_port <= w_out;
  end
endmodule

// File: tb/tb_pio_led_blink.sv
// tb_pio_led_blink: randomized bench for pio_led_blink against a cycle-count reference model.
// Blink phase is modelled as (cycles since PERIOD write / PERIOD) parity.
module tb_pio_led_blink;
  localparam logic [7:0] RV = 8'hA5;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  int          vecs = 0;
  int          errs = 0;
  logic [7:0]  m_data, m_mask, m_out;
  logic [23:0] m_period;
  int          m_n;
  always #5 clk = ~clk;
  pio_led_blink #(.WIDTH(8), .PRESCALE_W(24), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic m_phase();
    return m_period == 0 || ((m_n / int'(m_period)) % 2 == 0);
  endfunction
  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
`ifdef PIO_LED_BLINK_EN
      3'd1: return {24'd0, m_mask};
      3'd2: return {8'd0, m_period};
      3'd3: return {31'd0, m_phase()};
`endif
      default: return 32'd0;
    endcase
  endfunction
  task automatic step(input logic rst, input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic wr;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
    wr = cs && !wn;
    #1;
    if (!rst) check("readdata", readdata, m_read(a));
    @(posedge clk);
    if (rst) begin
      m_data = RV; m_mask = '0; m_period = '0; m_n = 0; m_out = '0;
    end else begin
      m_out = m_data & (~m_mask | {8{m_phase()}});
      if (wr && a == 3'd0) m_data = wd[7:0];
      if (wr && a == 3'd4) m_data = m_data | wd[7:0];
      if (wr && a == 3'd5) m_data = m_data & ~wd[7:0];
`ifdef PIO_LED_BLINK_EN
      if (wr && a == 3'd1) m_mask = wd[7:0];
      if (wr && a == 3'd2) m_period = wd[23:0];
      m_n = (wr && a == 3'd2) ? 0 : m_n + 1;
`endif
    end
    #1;
    check("out_port", {24'd0, out_port}, {24'd0, m_out});
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask
  task automatic idle(input logic [2:0] a);
    step(1'b0, 1'b0, 1'b1, a, 32'd0);
  endtask
  initial begin
    m_data = RV; m_mask = '0; m_period = '0; m_n = 0; m_out = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 32'h12);
    idle(0);
    idle(0);
    check("rv_out", {24'd0, out_port}, 32'h000000A5);
    check("rv_read", readdata, 32'h000000A5);
    wr(0, 32'hFFFF_FF0F);
    wr(4, 32'h0000_00F0);
    idle(0);
    check("outset_rd", readdata, 32'h000000FF);
    check("outset_out", {24'd0, out_port}, 32'h000000FF);
    wr(5, 32'h0000_0003);
    idle(0);
    check("outclr_rd", readdata, 32'h000000FC);
    idle(4);
    check("rd4", readdata, 32'd0);
    idle(5);
    check("rd5", readdata, 32'd0);
    wr(0, 32'hFF);
    wr(1, 32'h01);
    wr(2, 32'd4);
`ifdef PIO_LED_BLINK_EN
    for (int i = 0; i < 18; i++) idle(3);
    while (!(m_period == 4 && m_n % 4 == 3)) idle(3);
    wr(2, 32'd2);
    idle(3);
    check("wrap_phase", readdata, 32'd1);
    for (int i = 0; i < 8; i++) idle(3);
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h3C);
    idle(0);
    check("rst_data", readdata, 32'h000000A5);
    idle(3);
    check("rst_phase", readdata, 32'd1);
`else
    for (int i = 0; i < 6; i++) idle(0);
    idle(1);
    check("dis_rd1", readdata, 32'd0);
    idle(2);
    check("dis_rd2", readdata, 32'd0);
    idle(3);
    check("dis_rd3", readdata, 32'd0);
    check("dis_out", {24'd0, out_port}, 32'h000000FF);
`endif
    for (int i = 0; i < 600; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 0, a, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
